// File: rtl/as_top_mem_soc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : as_pack                                                       |
// | Purpose  : Shared sizes, opcode/funct3 encodings and ALU op set for the  |
// |            as_top_mem_soc RV64I-subset system.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package as_pack;

    localparam int XLEN            = 64;
    localparam int INSTR_WIDTH     = 32;
    localparam int IMEMDEPTH       = 256;
    localparam int IMEM_AW         = $clog2(IMEMDEPTH);
    localparam int DMEMDEPTH       = 128;
    localparam int DMEM_AW         = $clog2(DMEMDEPTH);
    localparam int NR_GPIOS        = 8;
    localparam int GPIO_ADDR_WIDTH = 4;
    localparam int IM_SCAN_LENGTH  = IMEM_AW + INSTR_WIDTH;

    localparam logic [GPIO_ADDR_WIDTH-1:0] IO_GPIO_IN  = 4'h0;
    localparam logic [GPIO_ADDR_WIDTH-1:0] IO_GPIO_OUT = 4'h4;
    localparam logic [GPIO_ADDR_WIDTH-1:0] IO_GPIO_OE  = 4'h8;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef enum logic [2:0] {
        F3_WORD   = 3'b010,
        F3_DOUBLE = 3'b011
    } mem_f3_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    // alt selects SUB/SRA; callers pass 0 wherever the alternate form is illegal
    function automatic alu_op_e decode_alu_op(input logic [2:0] f3, input logic alt);
        case (alu_f3_e'(f3))
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/as_top_mem_soc_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : as_alu                                                        |
// | Purpose  : 64-bit integer ALU with equality and signed/unsigned flags.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module as_alu
    import as_pack::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu
);

    logic [5:0] w_shamt;

    assign w_shamt = b[5:0];
    assign lt      = $signed(a) < $signed(b);
    assign ltu     = a < b;
    assign zero    = (result == '0);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << w_shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $signed(a) >>> w_shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/as_top_mem_soc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : as_top_mem_soc                                                |
// | Purpose  : Single-cycle RV64I-subset core with IMEM, DMEM, GPIO and a    |
// |            scan-chain IMEM loader.                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module as_top_mem_soc
    import as_pack::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                trst_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o
);

    logic [XLEN-1:0]        r_pc;
    logic [XLEN-1:0]        r_regs [1:31];
    logic [INSTR_WIDTH-1:0] r_imem [0:IMEMDEPTH-1];
    logic [XLEN-1:0]        r_dmem [0:DMEMDEPTH-1];
    logic [NR_GPIOS-1:0]    r_gpio_out;
    logic [NR_GPIOS-1:0]    r_gpio_oe;
    logic                   r_cs;
    logic [IM_SCAN_LENGTH-1:0] r_scan_reg;
    logic                   r_scan_armed;

    logic [INSTR_WIDTH-1:0] w_instr;
    opcode_e                w_opcode;
    logic [4:0]             w_rd, w_rs1, w_rs2;
    logic [2:0]             w_f3;
    logic [6:0]             w_f7;
    logic [XLEN-1:0]        w_rs1_val, w_rs2_val;
    logic [XLEN-1:0]        w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0]        w_pc_plus4, w_pc_next;

    assign w_instr    = r_imem[r_pc[IMEM_AW+1:2]];
    assign w_opcode   = opcode_e'(w_instr[6:0]);
    assign w_rd       = w_instr[11:7];
    assign w_f3       = w_instr[14:12];
    assign w_rs1      = w_instr[19:15];
    assign w_rs2      = w_instr[24:20];
    assign w_f7       = w_instr[31:25];
    assign w_rs1_val  = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val  = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + 64'd4;

    assign w_imm_i = {{52{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{52{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{52{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {{32{w_instr[31]}}, w_instr[31:12], 12'h000};
    assign w_imm_j = {{44{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    alu_op_e         w_alu_op;
    logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_res;
    logic            w_alu_zero, w_alu_lt, w_alu_ltu;
    logic            w_rd_we, w_link, w_load, w_store, w_word, w_jal, w_jalr, w_branch;

    always_comb begin
        w_alu_op = ALU_ADD;
        w_alu_a  = w_rs1_val;
        w_alu_b  = w_imm_i;
        w_rd_we  = 1'b0;
        w_link   = 1'b0;
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_word   = (w_f3 == F3_WORD);
        w_jal    = 1'b0;
        w_jalr   = 1'b0;
        w_branch = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_alu_a = '0;
                w_alu_b = w_imm_u;
                w_rd_we = 1'b1;
            end
            OP_AUIPC: begin
                w_alu_a = r_pc;
                w_alu_b = w_imm_u;
                w_rd_we = 1'b1;
            end
            OP_JAL: begin
                w_jal   = 1'b1;
                w_link  = 1'b1;
                w_rd_we = 1'b1;
            end
            OP_JALR: begin
                w_jalr  = (w_f3 == 3'b000);
                w_link  = w_jalr;
                w_rd_we = w_jalr;
            end
            OP_BRANCH: begin
                w_alu_op = ALU_SUB;
                w_alu_b  = w_rs2_val;
                w_branch = 1'b1;
            end
            OP_LOAD: begin
                w_load  = (w_f3 == F3_WORD) || (w_f3 == F3_DOUBLE);
                w_rd_we = w_load;
            end
            OP_STORE: begin
                w_alu_b = w_imm_s;
                w_store = (w_f3 == F3_WORD) || (w_f3 == F3_DOUBLE);
            end
            OP_IMM: begin
                w_alu_op = decode_alu_op(w_f3, (w_f3 == F3_SR) && w_instr[30]);
                // RV64 shift immediates keep imm[11:6] clear except the SRAI bit
                if (w_f3 == F3_SLL)
                    w_rd_we = (w_instr[31:26] == 6'd0);
                else if (w_f3 == F3_SR)
                    w_rd_we = !w_instr[31] && (w_instr[29:26] == 4'd0);
                else
                    w_rd_we = 1'b1;
            end
            OP_OP: begin
                w_alu_op = decode_alu_op(w_f3, w_instr[30]);
                w_alu_b  = w_rs2_val;
                w_rd_we  = (w_f7 == 7'h00) ||
                           ((w_f7 == 7'h20) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)));
            end
            default: ;
        endcase
    end

    as_alu u_alu (
        .op     (w_alu_op),
        .a      (w_alu_a),
        .b      (w_alu_b),
        .result (w_alu_res),
        .zero   (w_alu_zero),
        .lt     (w_alu_lt),
        .ltu    (w_alu_ltu)
    );

    logic w_taken;

    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            F3_BEQ:  w_taken = w_alu_zero;
            F3_BNE:  w_taken = !w_alu_zero;
            F3_BLT:  w_taken = w_alu_lt;
            F3_BGE:  w_taken = !w_alu_lt;
            F3_BLTU: w_taken = w_alu_ltu;
            F3_BGEU: w_taken = !w_alu_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_jal)
            w_pc_next = r_pc + w_imm_j;
        else if (w_jalr)
            w_pc_next = {w_alu_res[XLEN-1:1], 1'b0};
        else if (w_branch && w_taken)
            w_pc_next = r_pc + w_imm_b;
    end

    // Bit 10 selects IO; DMEM/IO indexing drops the low bits to align accesses
    logic                   w_io_hit, w_io_page;
    logic [GPIO_ADDR_WIDTH-1:0] w_io_off;
    logic [DMEM_AW-1:0]     w_dmem_idx;
    logic [XLEN-1:0]        w_io_rd, w_mem_raw, w_load_data, w_wb_data;
    logic [31:0]            w_word_rd;
    logic                   w_gpio_out_we, w_gpio_oe_we, w_dmem_we;

    assign w_io_hit   = w_alu_res[10];
    assign w_io_page  = (w_alu_res[9:GPIO_ADDR_WIDTH] == '0);
    assign w_io_off   = {w_alu_res[GPIO_ADDR_WIDTH-1:2], 2'b00};
    assign w_dmem_idx = w_alu_res[DMEM_AW+2:3];

    always_comb begin
        w_io_rd = '0;
        if (w_io_page) begin
            if (w_io_off == IO_GPIO_IN)
                w_io_rd = {{(XLEN-NR_GPIOS){1'b0}}, gpio_io};
            else if (w_io_off == IO_GPIO_OUT)
                w_io_rd = {{(XLEN-NR_GPIOS){1'b0}}, r_gpio_out};
            else if (w_io_off == IO_GPIO_OE)
                w_io_rd = {{(XLEN-NR_GPIOS){1'b0}}, r_gpio_oe};
        end
    end

    assign w_mem_raw     = w_io_hit ? w_io_rd : r_dmem[w_dmem_idx];
    assign w_word_rd     = (!w_io_hit && w_alu_res[2]) ? w_mem_raw[63:32] : w_mem_raw[31:0];
    assign w_load_data   = w_word ? {{32{w_word_rd[31]}}, w_word_rd} : w_mem_raw;
    assign w_wb_data     = w_load ? w_load_data : (w_link ? w_pc_plus4 : w_alu_res);
    assign w_gpio_out_we = w_store && w_io_hit && w_io_page && (w_io_off == IO_GPIO_OUT);
    assign w_gpio_oe_we  = w_store && w_io_hit && w_io_page && (w_io_off == IO_GPIO_OE);
    assign w_dmem_we     = w_store && !w_io_hit && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc <= '0;
            for (int i = 1; i < 32; i++)
                r_regs[i] <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_rd_we && (w_rd != 5'd0))
                r_regs[w_rd] <= w_wb_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gpio_out <= '0;
            r_gpio_oe  <= '1;
            r_cs       <= 1'b0;
        end else begin
            r_cs <= w_gpio_out_we;
            if (w_gpio_out_we)
                r_gpio_out <= w_rs2_val[NR_GPIOS-1:0];
            if (w_gpio_oe_we)
                r_gpio_oe <= w_rs2_val[NR_GPIOS-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_dmem_we) begin
            if (!w_word)
                r_dmem[w_dmem_idx] <= w_rs2_val;
            else if (w_alu_res[2])
                r_dmem[w_dmem_idx][63:32] <= w_rs2_val[31:0];
            else
                r_dmem[w_dmem_idx][31:0] <= w_rs2_val[31:0];
        end
    end

    assign cs_o = r_cs;

    for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pads
        assign gpio_io[g] = r_gpio_oe[g] ? r_gpio_out[g] : 1'bz;
    end

    // Scan loader: shift while tms is high, commit once on the first tms-low edge
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            r_scan_reg   <= '0;
            r_scan_armed <= 1'b0;
        end else if (tms_i) begin
            r_scan_reg   <= {tdi_i, r_scan_reg[IM_SCAN_LENGTH-1:1]};
            r_scan_armed <= 1'b1;
        end else begin
            r_scan_armed <= 1'b0;
        end
    end

    always_ff @(posedge tck_i) begin
        if (!trst_i && !tms_i && r_scan_armed)
            r_imem[r_scan_reg[IM_SCAN_LENGTH-1:INSTR_WIDTH]] <= r_scan_reg[INSTR_WIDTH-1:0];
    end

    assign tdo_o = r_scan_reg[0];

endmodule
`default_nettype wire

// File: tb/tb_as_top_mem_soc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_as_top_mem_soc                                             |
// | Purpose  : Directed programs scanned into IMEM, checked against hand-    |
// |            computed register, GPIO and strobe values.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_as_top_mem_soc;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tck_i = 1'b0;
    logic       trst_i = 1'b1;
    logic       tms_i = 1'b0;
    logic       tdi_i = 1'b0;
    logic       tdo_o;
    logic       cs_o;
    wire  [7:0] gpio_io;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] cs_vals [$];
    int         cs_cyc  [$];
    logic [31:0] prog   [$];
    logic       pad_hiz;

    as_top_mem_soc dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tck_i   (tck_i),
        .trst_i  (trst_i),
        .tms_i   (tms_i),
        .tdi_i   (tdi_i),
        .tdo_o   (tdo_o),
        .gpio_io (gpio_io),
        .cs_o    (cs_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (cs_o === 1'b1) begin
            cs_vals.push_back(gpio_io);
            cs_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] m, d, o;
        m = imm20; d = rd; o = op;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 'h13);
    endfunction

    function automatic logic [31:0] sd(input int rs2, input int rs1, input int imm);
        return enc_s(imm, rs2, rs1, 3);
    endfunction

    task automatic tck_pulse();
        #5 tck_i = 1'b1;
        #5 tck_i = 1'b0;
    endtask

    task automatic scan_word(input int addr, input logic [31:0] word);
        logic [39:0] v;
        v = {8'(addr), word};
        for (int i = 0; i < 40; i++) begin
            tms_i = 1'b1;
            tdi_i = v[i];
            tck_pulse();
        end
        tms_i = 1'b0;
        tck_pulse();
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++)
            scan_word(i, prog[i]);
        prog.delete();
    endtask

    task automatic start_run();
        cs_vals.delete();
        cs_cyc.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic stop_run();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #23 trst_i = 1'b0;
        #10;
        check_eq("rst_cs", {63'd0, cs_o}, 64'd0);
        check_eq("rst_pc", dut.r_pc, 64'd0);
        check_eq("rst_gpio", {56'd0, gpio_io}, 64'd0);

        // Program A: four arithmetic results plus a back-to-back SW to GPIO_OUT
        prog.push_back(addi(4, 0, 'h404));
        prog.push_back(addi(1, 0, 100));
        prog.push_back(addi(2, 0, 37));
        prog.push_back(enc_r(0, 2, 1, 0, 3));
        prog.push_back(sd(3, 4, 0));
        prog.push_back(addi(1, 0, -9));
        prog.push_back(addi(2, 0, -128));
        prog.push_back(enc_r(0, 2, 1, 0, 3));
        prog.push_back(sd(3, 4, 0));
        prog.push_back(addi(1, 0, -1));
        prog.push_back(enc_i(1, 1, 5, 1, 'h13));
        prog.push_back(addi(2, 0, 2));
        prog.push_back(enc_r(0, 2, 1, 0, 3));
        prog.push_back(sd(3, 4, 0));
        prog.push_back(addi(1, 0, 1));
        prog.push_back(enc_i(63, 1, 1, 1, 'h13));
        prog.push_back(addi(1, 1, 255));
        prog.push_back(enc_r(0, 1, 1, 0, 3));
        prog.push_back(sd(3, 4, 0));
        prog.push_back(enc_s(0, 1, 4, 2));
        prog.push_back(enc_j(0, 0));
        load_prog();
        start_run();
        repeat (30) @(negedge clk_i);
        check_eq("a_pulses", 64'(cs_vals.size()), 64'd5);
        if (cs_vals.size() == 5) begin
            check_eq("a_add_pos", {56'd0, cs_vals[0]}, 64'h89);
            check_eq("a_add_neg", {56'd0, cs_vals[1]}, 64'h77);
            check_eq("a_wrap",    {56'd0, cs_vals[2]}, 64'h01);
            check_eq("a_wrap_hi", {56'd0, cs_vals[3]}, 64'hFE);
            check_eq("a_sw_low",  {56'd0, cs_vals[4]}, 64'hFF);
            check_eq("a_b2b", 64'(cs_cyc[4] - cs_cyc[3]), 64'd1);
        end
        check_eq("a_x3", dut.r_regs[3], 64'h0000_0000_0000_01FE);
        stop_run();

        // Program B: loads/stores, compares, shifts, branches, jumps, x0, unknown opcode
        prog.push_back(addi(1, 0, -3));
        prog.push_back(sd(1, 0, 16));
        prog.push_back(enc_i(16, 0, 3, 2, 'h03));
        prog.push_back(enc_u('h80000, 5, 'h37));
        prog.push_back(addi(5, 5, 'h123));
        prog.push_back(enc_s(28, 5, 0, 2));
        prog.push_back(enc_i(28, 0, 2, 6, 'h03));
        prog.push_back(enc_r(0, 0, 1, 2, 7));
        prog.push_back(enc_r(0, 0, 1, 3, 8));
        prog.push_back(enc_i('h401, 1, 5, 9, 'h13));
        prog.push_back(enc_b(8, 0, 1, 4));
        prog.push_back(addi(10, 0, 1));
        prog.push_back(enc_j(8, 11));
        prog.push_back(addi(10, 0, 2));
        prog.push_back(addi(0, 0, 7));
        prog.push_back(enc_r('h20, 1, 0, 0, 12));
        prog.push_back(enc_u(0, 13, 'h17));
        prog.push_back(enc_i(12, 13, 0, 14, 'h67));
        prog.push_back(addi(10, 0, 3));
        prog.push_back(enc_b(8, 2, 1, 0));
        prog.push_back(addi(10, 0, 4));
        prog.push_back(addi(15, 0, 11));
        prog.push_back(32'h0000_0F8B);
        prog.push_back(enc_j(0, 0));
        load_prog();
        start_run();
        repeat (40) @(negedge clk_i);
        check_eq("b_ld",    dut.r_regs[2],  64'hFFFF_FFFF_FFFF_FFFD);
        check_eq("b_lui",   dut.r_regs[5],  64'hFFFF_FFFF_8000_0123);
        check_eq("b_lw",    dut.r_regs[6],  64'hFFFF_FFFF_8000_0123);
        check_eq("b_slt",   dut.r_regs[7],  64'd1);
        check_eq("b_sltu",  dut.r_regs[8],  64'd0);
        check_eq("b_srai",  dut.r_regs[9],  64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("b_skip",  dut.r_regs[10], 64'd0);
        check_eq("b_jal",   dut.r_regs[11], 64'd52);
        check_eq("b_sub",   dut.r_regs[12], 64'd3);
        check_eq("b_auipc", dut.r_regs[13], 64'd64);
        check_eq("b_jalr",  dut.r_regs[14], 64'd72);
        check_eq("b_x0",    dut.r_regs[15], 64'd11);
        check_eq("b_nop",   dut.r_regs[31], 64'd0);
        check_eq("b_pc",    dut.r_pc,       64'd92);
        stop_run();

        // Program D: tri-state the pads, store anyway, read IO registers back
        prog.push_back(addi(4, 0, 'h404));
        prog.push_back(addi(3, 0, 'h5A));
        prog.push_back(sd(0, 4, 4));
        prog.push_back(sd(3, 4, 0));
        prog.push_back(enc_i(4, 4, 3, 7, 'h03));
        prog.push_back(enc_i(0, 4, 3, 8, 'h03));
        prog.push_back(enc_j(0, 0));
        load_prog();
        start_run();
        repeat (10) @(negedge clk_i);
        check_eq("d_pulses", 64'(cs_vals.size()), 64'd1);
        check_eq("d_oe_rd",  dut.r_regs[7], 64'd0);
        check_eq("d_out_rd", dut.r_regs[8], 64'h5A);
        pad_hiz = (gpio_io === 8'hzz) || (gpio_io === 8'h00);
        check_eq("d_pad_hiz", {63'd0, pad_hiz}, 64'd1);
        stop_run();

        // Same program again, reset asserted while the strobe is high
        start_run();
        repeat (4) @(posedge clk_i);
        #1;
        check_eq("d_cs_pre_rst", {63'd0, cs_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        check_eq("d_cs_async", {63'd0, cs_o}, 64'd0);
        check_eq("d_pc_async", dut.r_pc, 64'd0);
        check_eq("d_gpio_rst", {56'd0, gpio_io}, 64'd0);

        // Scan loader: overwrite word 0 and 1, then run
        prog.push_back(addi(1, 0, 5));
        prog.push_back(enc_j(0, 0));
        load_prog();
        check_eq("s_tdo", {63'd0, tdo_o}, 64'd1);
        start_run();
        repeat (5) @(negedge clk_i);
        check_eq("s_x1", dut.r_regs[1], 64'd5);
        check_eq("s_pc", dut.r_pc, 64'd4);
        stop_run();
        trst_i = 1'b1;
        #1;
        check_eq("s_trst_tdo", {63'd0, tdo_o}, 64'd0);
        trst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
